tour_cmd_sched: RTL and testbench

- Host-side command scheduler for the Knight's Tour remote link. It buffers a queue of 16-bit commands (CAL_GYRO, tour start, moves) and issues them one at a time to the UART command wrapper through its snd_cmd/cmd_snt handshake.
- After each send it waits for the 8-bit response. Only a positive ack pops the queue.
- It retries on timeout and halts with an error code on a negative response.
- It sits between bench or host logic and the RemoteComm-class transmitter, replacing hand-sequenced SendCmd/ChkPosAck calls.

---
 rtl/tour_cmd_sched.sv | 179 +++++++++++++++++
 tb/tb_tour_cmd_sched.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tour_cmd_sched.sv
// rtl/tour_cmd_sched.sv - queued command scheduler with ack/retry handshake to the UART command wrapper
// Define TOUR_CMD_SCHED_STATS_EN to build the acked_cnt / retry_cnt statistics counters.
module tour_cmd_sched #(
  parameter int          DEPTH        = 32,
  parameter int          TIMEOUT_CLKS = 1000000,
  parameter int          MAX_RETRY    = 3,
  parameter logic [7:0]  ACK_VAL      = 8'hA5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [15:0]                wr_cmd,
  input  logic                       go,
  input  logic                       abort,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf,
  output logic                       snd_cmd,
  output logic [15:0]                cmd,
  input  logic                       cmd_snt,
  input  logic                       resp_rdy,
  input  logic [7:0]                 resp,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [1:0]                 err_code,
  output logic [15:0]                acked_cnt,
  output logic [15:0]                retry_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam int RW = $clog2(MAX_RETRY + 1) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SEND, S_WAIT_SNT, S_WAIT_RESP, S_NEXT, S_DONE, S_ERR
  } state_t;

  state_t        state;
  logic [15:0]   mem [DEPTH];
  logic [AW:0]   wptr, rptr;
  logic [TW-1:0] tcnt;
  logic [RW-1:0] rcnt;
  logic          push;

  assign count = wptr - rptr;
  assign empty = (wptr == rptr);
  assign full  = (count == CW'(DEPTH));
  assign busy  = !(state inside {S_IDLE, S_DONE, S_ERR});
  // abort wins over a same-cycle write, so the flush leaves the queue truly empty
  assign push  = wr_en && !full && !abort;

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= wr_cmd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      wptr     <= '0;
      rptr     <= '0;
      tcnt     <= '0;
      rcnt     <= '0;
      ovf      <= 1'b0;
      snd_cmd  <= 1'b0;
      cmd      <= 16'h0000;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'b00;
    end else begin
      snd_cmd <= 1'b0;
      if (wr_en && full && !abort) ovf <= 1'b1;
      if (abort) begin
        wptr     <= '0;
        rptr     <= '0;
        tcnt     <= '0;
        rcnt     <= '0;
        err      <= 1'b1;
        err_code <= 2'b11;
        state    <= S_ERR;
      end else begin
        if (push) wptr <= wptr + 1'b1;
        case (state)
          S_IDLE, S_DONE, S_ERR: begin
            if (go) begin
              err      <= 1'b0;
              err_code <= 2'b00;
              if (!empty) begin
                done  <= 1'b0;
                state <= S_LOAD;
              end else begin
                done  <= 1'b1;
                state <= S_DONE;
              end
            end
          end
          S_LOAD: begin
            cmd     <= mem[rptr[AW-1:0]];
            tcnt    <= '0;
            rcnt    <= '0;
            snd_cmd <= 1'b1;
            state   <= S_SEND;
          end
          S_SEND: state <= S_WAIT_SNT;
          S_WAIT_SNT: begin
            if (cmd_snt) begin
              tcnt  <= '0;
              state <= S_WAIT_RESP;
            end
          end
          S_WAIT_RESP: begin
            // a response on the final timeout cycle is still honoured
            if (resp_rdy) begin
              if (resp == ACK_VAL) begin
                rptr  <= rptr + 1'b1;
                rcnt  <= '0;
                state <= S_NEXT;
              end else begin
                err      <= 1'b1;
                err_code <= 2'b10;
                state    <= S_ERR;
              end
            end else if (tcnt == TW'(TIMEOUT_CLKS - 1)) begin
              tcnt <= '0;
              if (rcnt < RW'(MAX_RETRY)) begin
                rcnt    <= rcnt + 1'b1;
                snd_cmd <= 1'b1;
                state   <= S_SEND;
              end else begin
                err      <= 1'b1;
                err_code <= 2'b01;
                state    <= S_ERR;
              end
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
          S_NEXT: begin
            if (!empty) begin
              state <= S_LOAD;
            end else begin
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef TOUR_CMD_SCHED_STATS_EN
  logic [15:0] acked_q, retry_q;
  logic        ack_evt, retry_evt;

  assign ack_evt   = !abort && state == S_WAIT_RESP && resp_rdy && resp == ACK_VAL;
  assign retry_evt = !abort && state == S_WAIT_RESP && !resp_rdy &&
                     tcnt == TW'(TIMEOUT_CLKS - 1) && rcnt < RW'(MAX_RETRY);

  always_ff @(posedge clk) begin
    if (rst) begin
      acked_q <= 16'h0000;
      retry_q <= 16'h0000;
    end else begin
      if (ack_evt && acked_q != 16'hFFFF) acked_q <= acked_q + 16'd1;
      if (retry_evt && retry_q != 16'hFFFF) retry_q <= retry_q + 16'd1;
    end
  end

  assign acked_cnt = acked_q;
  assign retry_cnt = retry_q;
`else
  assign acked_cnt = 16'h0000;
  assign retry_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_tour_cmd_sched.sv
// tb/tb_tour_cmd_sched.sv - self-checking bench for tour_cmd_sched
module tb_tour_cmd_sched;

  localparam int         DEPTH = 8;
  localparam int         TOUT  = 100;
  localparam logic [7:0] ACK   = 8'hA5;
`ifdef TOUR_CMD_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [15:0] wr_cmd = 16'h0000;
  logic        go = 1'b0;
  logic        abort = 1'b0;
  logic        full, empty, ovf, snd_cmd, busy, done, err;
  logic [3:0]  count;
  logic [15:0] cmd, acked_cnt, retry_cnt;
  logic [1:0]  err_code;
  logic        cmd_snt = 1'b0;
  logic        resp_rdy = 1'b0;
  logic [7:0]  resp = 8'h00;

  int errors = 0;
  int checks = 0;

  tour_cmd_sched #(.DEPTH(DEPTH), .TIMEOUT_CLKS(TOUT), .MAX_RETRY(3), .ACK_VAL(ACK)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_cmd(wr_cmd), .go(go), .abort(abort),
    .full(full), .empty(empty), .count(count), .ovf(ovf), .snd_cmd(snd_cmd), .cmd(cmd),
    .cmd_snt(cmd_snt), .resp_rdy(resp_rdy), .resp(resp), .busy(busy), .done(done),
    .err(err), .err_code(err_code), .acked_cnt(acked_cnt), .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  // transmitter/responder model and send monitor
  logic [15:0] sent_q[$];
  logic [7:0]  resp_log[$];
  int          snt_dly = 0;
  int          rsp_dly = 0;
  int          resp_delay = 3;
  bit          resp_en = 1'b1;
  bit          resp_rand = 1'b0;
  bit          nack_ok = 1'b1;
  logic [7:0]  resp_fixed = 8'hA5;

  always @(negedge clk) begin
    logic [7:0] v;
    cmd_snt  = 1'b0;
    resp_rdy = 1'b0;
    if (rst) begin
      snt_dly = 0;
      rsp_dly = 0;
    end else begin
      if (snt_dly > 0) begin
        snt_dly--;
        if (snt_dly == 0) begin
          cmd_snt = 1'b1;
          if (resp_en) rsp_dly = resp_delay;
        end
      end else if (rsp_dly > 0) begin
        rsp_dly--;
        if (rsp_dly == 0) begin
          if (resp_rand && nack_ok && $urandom_range(0, 3) == 0) v = 8'($urandom_range(0, 255));
          else if (resp_rand) v = ACK;
          else v = resp_fixed;
          resp     = v;
          resp_rdy = 1'b1;
          resp_log.push_back(v);
        end
      end
      if (snd_cmd) begin
        snt_dly = 2;
        sent_q.push_back(cmd);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    sent_q.delete();
    resp_log.delete();
  endtask

  task automatic push(input logic [15:0] c);
    wr_en = 1'b1; wr_cmd = c;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk({name, "_timeout"}, 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [15:0] c;
    logic [7:0]  r;
    logic        d;
    logic        e;
    logic [1:0]  code;
    int          cnt;
  } vec_t;

  vec_t vt[4];

  initial begin
    logic [15:0] mq[$];
    int n, nerr;

    vt[0] = '{c: 16'h2000, r: 8'hA5, d: 1'b1, e: 1'b0, code: 2'b00, cnt: 0};
    vt[1] = '{c: 16'h7033, r: 8'h5A, d: 1'b0, e: 1'b1, code: 2'b10, cnt: 1};
    vt[2] = '{c: 16'hFFFF, r: 8'h00, d: 1'b0, e: 1'b1, code: 2'b10, cnt: 1};
    vt[3] = '{c: 16'h0000, r: 8'hA5, d: 1'b1, e: 1'b0, code: 2'b00, cnt: 0};

    do_reset();
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_snd", 32'(snd_cmd), 0);
    chk("rst_cmd", 32'(cmd), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", {err, err_code}, 0);
    chk("rst_acked", 32'(acked_cnt), 0);

    // two acked commands, go-to-send latency
    push(16'h2000);
    push(16'h7033);
    chk("two_count", 32'(count), 2);
    pulse_go();
    chk("lat_not_yet", 32'(snd_cmd), 0);
    @(negedge clk);
    chk("lat_snd", 32'(snd_cmd), 1);
    chk("lat_cmd", 32'(cmd), 32'h2000);
    wait_idle("two", 200);
    chk("two_nsent", sent_q.size(), 2);
    chk("two_sent0", 32'(sent_q[0]), 32'h2000);
    chk("two_sent1", 32'(sent_q[1]), 32'h7033);
    chk("two_done", 32'(done), 1);
    chk("two_empty", 32'(empty), 1);
    chk("two_count0", 32'(count), 0);
    chk("two_acked", 32'(acked_cnt), STATS ? 2 : 0);

    // single-command vectors
    for (int i = 0; i < 4; i++) begin
      do_reset();
      resp_fixed = vt[i].r;
      push(vt[i].c);
      pulse_go();
      wait_idle("vec", 100);
      chk($sformatf("vec%0d_sent", i), 32'(sent_q[0]), 32'(vt[i].c));
      chk($sformatf("vec%0d_nsent", i), sent_q.size(), 1);
      chk($sformatf("vec%0d_done", i), 32'(done), 32'(vt[i].d));
      chk($sformatf("vec%0d_err", i), {err, err_code}, {vt[i].e, vt[i].code});
      chk($sformatf("vec%0d_count", i), 32'(count), vt[i].cnt);
    end

    // no response: one send plus three retries, then error 01
    do_reset();
    resp_en = 1'b0;
    push(16'h4001);
    pulse_go();
    wait_idle("tmo", 2000);
    chk("tmo_nsent", sent_q.size(), 4);
    chk("tmo_cmd", 32'(sent_q[3]), 32'h4001);
    chk("tmo_err", {err, err_code}, 3'b101);
    chk("tmo_count", 32'(count), 1);
    chk("tmo_retry", 32'(retry_cnt), STATS ? 3 : 0);
    resp_en = 1'b1;

    // negative response keeps the head; go retries it
    do_reset();
    resp_fixed = 8'h5A;
    push(16'h1234);
    pulse_go();
    wait_idle("nak", 100);
    chk("nak_err", {err, err_code}, 3'b110);
    chk("nak_count", 32'(count), 1);
    chk("nak_done", 32'(done), 0);
    resp_fixed = ACK;
    pulse_go();
    wait_idle("nak2", 100);
    chk("nak2_done", 32'(done), 1);
    chk("nak2_err", {err, err_code}, 0);
    chk("nak2_nsent", sent_q.size(), 2);
    chk("nak2_cmd", 32'(sent_q[1]), 32'h1234);
    chk("nak2_empty", 32'(empty), 1);

    // fill to DEPTH, overflow write dropped
    do_reset();
    for (int i = 0; i < DEPTH; i++) push(16'h0100 + 16'(i));
    chk("full_full", 32'(full), 1);
    chk("full_count", 32'(count), DEPTH);
    chk("full_ovf0", 32'(ovf), 0);
    push(16'hDEAD);
    chk("ovf_ovf", 32'(ovf), 1);
    chk("ovf_count", 32'(count), DEPTH);
    pulse_go();
    wait_idle("full", 400);
    chk("full_nsent", sent_q.size(), DEPTH);
    chk("full_last", 32'(sent_q[DEPTH-1]), 32'h0107);
    chk("full_done", 32'(done), 1);
    chk("full_ovf_sticky", 32'(ovf), 1);

    // abort in WAIT_RESP with a same-cycle write
    do_reset();
    resp_delay = 20;
    push(16'hA001); push(16'hA002); push(16'hA003);
    pulse_go();
    n = 0;
    while (!snd_cmd && n < 20) begin @(negedge clk); n++; end
    chk("abt_snd_seen", 32'(snd_cmd), 1);
    repeat (5) @(negedge clk);
    abort = 1'b1; wr_en = 1'b1; wr_cmd = 16'hBEEF;
    @(negedge clk);
    abort = 1'b0; wr_en = 1'b0;
    chk("abt_err", {err, err_code}, 3'b111);
    chk("abt_empty", 32'(empty), 1);
    chk("abt_count", 32'(count), 0);
    chk("abt_busy", 32'(busy), 0);
    repeat (30) @(negedge clk);
    chk("abt_late_nsent", sent_q.size(), 1);
    chk("abt_late_err", {err, err_code}, 3'b111);
    chk("abt_late_empty", 32'(empty), 1);
    resp_delay = 3;

    // reset while waiting for cmd_snt
    do_reset();
    push(16'h3333);
    pulse_go();
    n = 0;
    while (!snd_cmd && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mrst_snd", 32'(snd_cmd), 0);
    chk("mrst_cmd", 32'(cmd), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_flags", {done, err, err_code, ovf, full}, 0);
    chk("mrst_empty", 32'(empty), 1);
    chk("mrst_count", 32'(count), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    sent_q.delete();
    pulse_go();
    chk("mrst_done", 32'(done), 1);
    repeat (10) @(negedge clk);
    chk("mrst_nsent", sent_q.size(), 0);

    // randomized rounds against a queue model
    do_reset();
    resp_rand = 1'b1;
    for (int r = 0; r < 12; r++) begin
      sent_q.delete();
      resp_log.delete();
      mq.delete();
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        mq.push_back(16'($urandom));
        push(mq[i]);
      end
      nack_ok = 1'b1;
      nerr = 0;
      pulse_go();
      wait_idle("rnd", 400);
      while (err && nerr < 8) begin
        chk("rnd_err_code", 32'(err_code), 2);
        nerr++;
        if (nerr >= 3) nack_ok = 1'b0;
        pulse_go();
        wait_idle("rnd", 400);
      end
      chk("rnd_done", 32'(done), 1);
      chk("rnd_nresp", resp_log.size(), sent_q.size());
      foreach (sent_q[i]) begin
        if (mq.size() == 0) chk("rnd_extra_send", sent_q.size(), i);
        else begin
          chk($sformatf("rnd%0d_send%0d", r, i), 32'(sent_q[i]), 32'(mq[0]));
          if (resp_log[i] == ACK) void'(mq.pop_front());
        end
      end
      chk("rnd_model_empty", mq.size(), 0);
      chk("rnd_count", 32'(count), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
